// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the ALU op decoder and the shift sequencer.
// The decoder drives the master side; the sequencer owns the slave side.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic             right_shift;
  logic             rotate;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out1;
  logic [WIDTH-1:0] data_out2;

  modport master (
    output start, right_shift, rotate, amount, data_in1, data_in2,
    input  busy, done, data_out1, data_out2
  );

  modport slave (
    input  start, right_shift, rotate, amount, data_in1, data_in2,
    output busy, done, data_out1, data_out2
  );
endinterface

// File: rtl/shift_sequencer.sv
// Steps two operand lanes one bit per clock until the requested amount is reached.
// Latency amount+1 cycles to done (1 for amount 0); start is ignored while busy.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_right;
  logic             r_rotate;
  logic             w_right_nxt;
  logic             w_rotate_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_dat1;
  logic [WIDTH-1:0] r_dat2;
  logic [WIDTH-1:0] w_dat1_nxt;
  logic [WIDTH-1:0] w_dat2_nxt;

  // One single-bit step; the fill bit is either zero or the bit falling off the far end.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] r,
    input logic             right,
    input logic             rot
  );
    logic w_fill;
    if (right) begin
      w_fill = rot ? r[0] : 1'b0;
      return {w_fill, r[WIDTH-1:1]};
    end else begin
      w_fill = rot ? r[WIDTH-1] : 1'b0;
      return {r[WIDTH-2:0], w_fill};
    end
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_right  <= 1'b0;
      r_rotate <= 1'b0;
      r_cnt    <= '0;
      r_dat1   <= '0;
      r_dat2   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_right  <= w_right_nxt;
      r_rotate <= w_rotate_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dat1   <= w_dat1_nxt;
      r_dat2   <= w_dat2_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_right_nxt  = r_right;
    w_rotate_nxt = r_rotate;
    w_cnt_nxt    = r_cnt;
    w_dat1_nxt   = r_dat1;
    w_dat2_nxt   = r_dat2;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_right_nxt  = bus.right_shift;
          w_rotate_nxt = bus.rotate;
          w_cnt_nxt    = bus.amount;
          w_dat1_nxt   = bus.data_in1;
          w_dat2_nxt   = bus.data_in2;
          w_state_nxt  = (bus.amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_dat1_nxt = f_step(r_dat1, r_right, r_rotate);
        w_dat2_nxt = f_step(r_dat2, r_right, r_rotate);
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        // Count of one means this step is the last; zero cannot occur here but is treated the same.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.data_out1 = r_dat1;
  assign bus.data_out2 = r_dat2;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed scenarios plus randomized requests against a closed-form model.
module tb_shift_sequencer;
  localparam int W  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus();

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Result of shifting x by n positions, computed directly from n rather than step by step.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input logic right,
                                             input logic rot, input int n);
    int v;
    int k;
    v = int'(x);
    if (rot) begin
      k = n % W;
      v = right ? ((v >> k) | (v << (W - k))) : ((v << k) | (v >> (W - k)));
    end else begin
      v = (n >= W) ? 0 : (right ? (v >> n) : (v << n));
    end
    return v[W-1:0];
  endfunction

  function automatic logic [2*W+1:0] obs();
    return {bus.busy, bus.done, bus.data_out1, bus.data_out2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic right,
                         input logic rot, input logic [CW-1:0] amt);
    bus.data_in1    = a;
    bus.data_in2    = b;
    bus.right_shift = right;
    bus.rotate      = rot;
    bus.amount      = amt;
    bus.start       = 1'b1;
  endtask

  // Present a request and let edge E0 accept it; returns just after E0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic right,
                          input logic rot, input logic [CW-1:0] amt);
    set_req(a, b, right, rot, amt);
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*W+1:0] got;
    rst = 1'b0;
    bus.start = 1'b0; bus.right_shift = 1'b0; bus.rotate = 1'b0;
    bus.amount = '0; bus.data_in1 = '0; bus.data_in2 = '0;
    #2 rst = 1'b1;
    #1;
    got = obs();
    n_checks++;
    if (got !== 10'b0) $display("FAIL reset_initial got=%b exp=%b", got, 10'b0);
    else n_pass++;
    step();
    rst = 1'b0;
    start_op(4'b0110, 4'b1001, 1'b0, 1'b1, 3'd7);
    step();
    got = obs();
    n_checks++;
    if (got !== {2'b10, 4'b1100, 4'b0011}) $display("FAIL reset_preshift got=%b exp=%b", got, {2'b10, 4'b1100, 4'b0011});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    got = obs();
    n_checks++;
    if (got !== 10'b0) $display("FAIL reset_async got=%b exp=%b", got, 10'b0);
    else n_pass++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_logical_left();
    logic [2*W+1:0] exp_t [3];
    int busy_cycles = 0;
    exp_t[0] = {2'b10, 4'b1010, 4'b0101};
    exp_t[1] = {2'b11, 4'b0100, 4'b1010};
    exp_t[2] = {2'b00, 4'b0100, 4'b1010};
    start_op(4'b1010, 4'b0101, 1'b0, 1'b0, 3'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      if (bus.busy === 1'b1) busy_cycles++;
      n_checks++;
      if (obs() !== exp_t[k]) $display("FAIL lsl1 k=%0d got=%b exp=%b", k, obs(), exp_t[k]);
      else n_pass++;
    end
    n_checks++;
    if (busy_cycles != 2) $display("FAIL lsl1_busy_len got=%0d exp=2", busy_cycles);
    else n_pass++;
  endtask

  task automatic test_rotate_right();
    logic [2*W+1:0] exp_t [5];
    exp_t[0] = {2'b10, 4'b1100, 4'b0011};
    exp_t[1] = {2'b10, 4'b0110, 4'b1001};
    exp_t[2] = {2'b10, 4'b0011, 4'b1100};
    exp_t[3] = {2'b11, 4'b1001, 4'b0110};
    exp_t[4] = {2'b00, 4'b1001, 4'b0110};
    start_op(4'b1100, 4'b0011, 1'b1, 1'b1, 3'd3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      n_checks++;
      if (obs() !== exp_t[k]) $display("FAIL ror3 k=%0d got=%b exp=%b", k, obs(), exp_t[k]);
      else n_pass++;
    end
  endtask

  task automatic test_amount_zero();
    start_op(4'b1010, 4'b0101, 1'b0, 1'b1, 3'd0);
    n_checks++;
    if (obs() !== {2'b11, 4'b1010, 4'b0101}) $display("FAIL amt0_done got=%b exp=%b", obs(), {2'b11, 4'b1010, 4'b0101});
    else n_pass++;
    step();
    n_checks++;
    if (obs() !== {2'b00, 4'b1010, 4'b0101}) $display("FAIL amt0_idle got=%b exp=%b", obs(), {2'b00, 4'b1010, 4'b0101});
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    logic [2*W+1:0] exp_t [6];
    exp_t[0] = {2'b10, 4'b1111, 4'b1000};
    exp_t[1] = {2'b10, 4'b0111, 4'b0100};
    exp_t[2] = {2'b10, 4'b0011, 4'b0010};
    exp_t[3] = {2'b10, 4'b0001, 4'b0001};
    exp_t[4] = {2'b10, 4'b0000, 4'b0000};
    exp_t[5] = {2'b11, 4'b0000, 4'b0000};
    start_op(4'b1111, 4'b1000, 1'b1, 1'b0, 3'd5);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      bus.start = 1'b0;
      n_checks++;
      if (obs() !== exp_t[k]) $display("FAIL lsr5 k=%0d got=%b exp=%b", k, obs(), exp_t[k]);
      else n_pass++;
      if (k == 2) set_req(4'b0001, 4'b0001, 1'b0, 1'b1, 3'd1);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (obs() !== 10'b0) $display("FAIL lsr5_no_extra k=%0d got=%b exp=%b", k, obs(), 10'b0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [2*W+1:0] exp_t [3];
    exp_t[0] = {2'b10, 4'b0011, 4'b0001};
    exp_t[1] = {2'b10, 4'b0110, 4'b0010};
    exp_t[2] = {2'b11, 4'b1100, 4'b0100};
    start_op(4'b0001, 4'b0010, 1'b0, 1'b1, 3'd3);
    step();
    step();
    n_checks++;
    if (obs() !== {2'b10, 4'b0100, 4'b1000}) $display("FAIL rol3_e2 got=%b exp=%b", obs(), {2'b10, 4'b0100, 4'b1000});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 10'b0) $display("FAIL rol3_reset got=%b exp=%b", obs(), 10'b0);
    else n_pass++;
    #1 rst = 1'b0;
    set_req(4'b0011, 4'b0001, 1'b0, 1'b0, 3'd2);
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      n_checks++;
      if (obs() !== exp_t[k]) $display("FAIL post_reset_lsl2 k=%0d got=%b exp=%b", k, obs(), exp_t[k]);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [2*W+1:0] exp_t [8];
    exp_t[0] = {2'b10, 4'b0011, 4'b1001};
    exp_t[1] = {2'b11, 4'b0110, 4'b0010};
    exp_t[2] = {2'b00, 4'b0110, 4'b0010};
    exp_t[3] = {2'b11, 4'b1111, 4'b0000};
    exp_t[4] = {2'b00, 4'b1111, 4'b0000};
    exp_t[5] = {2'b10, 4'b0001, 4'b1000};
    exp_t[6] = {2'b10, 4'b1000, 4'b0100};
    exp_t[7] = {2'b11, 4'b0100, 4'b0010};
    set_req(4'b0011, 4'b1001, 1'b0, 1'b0, 3'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (obs() !== exp_t[k]) $display("FAIL b2b k=%0d got=%b exp=%b", k, obs(), exp_t[k]);
      else n_pass++;
      if (k == 2) set_req(4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0);
      if (k == 4) set_req(4'b0001, 4'b1000, 1'b1, 1'b1, 3'd2);
    end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic           right, rot;
    logic [CW-1:0]  amt;
    logic [2*W+1:0] exp_v;
    int             gap;
    for (int t = 0; t < 40; t++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      right = 1'($urandom);
      rot   = 1'($urandom);
      amt   = CW'($urandom);
      gap   = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      set_req(a, b, right, rot, amt);
      for (int k = 0; k <= int'(amt) + 1; k++) begin
        step();
        bus.start       = 1'($urandom);
        bus.data_in1    = W'($urandom);
        bus.data_in2    = W'($urandom);
        bus.right_shift = 1'($urandom);
        bus.rotate      = 1'($urandom);
        bus.amount      = CW'($urandom);
        if (k <= int'(amt)) begin
          exp_v = {1'b1, (k == int'(amt)), ref_shift(a, right, rot, k), ref_shift(b, right, rot, k)};
        end else begin
          exp_v = {2'b00, ref_shift(a, right, rot, k - 1), ref_shift(b, right, rot, k - 1)};
          bus.start = 1'b0;
        end
        n_checks++;
        if (obs() !== exp_v)
          $display("FAIL rand t=%0d a=%b b=%b r=%0d rot=%0d amt=%0d k=%0d got=%b exp=%b",
                   t, a, b, right, rot, amt, k, obs(), exp_v);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_logical_left();
    test_rotate_right();
    test_amount_zero();
    test_ignore_start();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the ALU's four-bit shift datapath. It accepts a shift request (two operands, direction, logical/rotate mode, shift amount) through a start/busy/done handshake. It then steps the operand pair one bit position per clock until the requested amount is reached and presents the results. It sits between the ALU op decoder and the shift result mux, so that shifts by more than one position are sequenced in hardware instead of being issued from the testbench or decoder one bit at a time.

## Interface
- WIDTH, 4: operand width in bits (both lanes).
- CNT_W, 3: shift-amount width; amounts 0 .. 2^CNT_W-1 are legal.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- right_shift  input  1  1 = shift right, 0 = shift left; captured at accept.
- rotate  input  1  1 = rotate, 0 = logical (zero fill); captured at accept.
- amount  input  CNT_W  number of single-bit shift steps; captured at accept.
- data_in1  input  WIDTH  lane-1 operand; captured at accept.
- data_in2  input  WIDTH  lane-2 operand; captured at accept.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; results are final.
- data_out1  output  WIDTH  lane-1 working/result register.
- data_out2  output  WIDTH  lane-2 working/result register.

## Operation
- States: IDLE, SHIFT, DONE; 2-bit state register.
- Registers: the state register; the captured direction and mode; a CNT_W-bit down-counter; two WIDTH-bit working registers driving data_out1/data_out2.
- IDLE:
  - On start=1, accept the request: load data_in1/2 into the working registers, capture right_shift and rotate, and load the counter with amount.
  - amount==0: go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT: each clock, apply one step to both lanes with the captured direction/mode, then decrement the counter. When the counter reaches 0 after the step, go to DONE.
- Step definitions, for r = working register:
  - Logical left: {r[W-2:0],0}.
  - Logical right: {0,r[W-1:1]}.
  - Rotate left: {r[W-2:0],r[W-1]}.
  - Rotate right: {r[0],r[W-1:1]}.
- Amount >= WIDTH is legal:
  - Logical mode yields all zeros.
  - Rotate mode wraps, so the result equals a rotate by amount mod WIDTH.
  - Still costs amount cycles.
- DONE: done=1, working registers hold; unconditionally go to IDLE next clock.
- start while busy (SHIFT or DONE) is ignored; captured fields do not change.
- data_out1/2 hold the last result in IDLE until the next accepted start overwrites them.
- Input changes after accept have no effect on the operation in flight.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT):
  - state=IDLE, counter=0, captured fields=0.
  - data_out1=data_out2=0, busy=0, done=0.
  - Takes effect immediately, without waiting for a clock edge.
  - After deassertion, the first start is accepted at the next rising edge.
- Edge E0 samples start=1 in IDLE.
- For amount N>0:
  - Shift steps occur at edges E1..EN.
  - State becomes DONE at EN.
  - done is high for the cycle between EN and EN+1.
  - State is IDLE after EN+1.
- For N=0: done is high for the cycle between E0 and E1, with outputs equal to the inputs.
- busy:
  - Rises after E0 and falls after the DONE cycle.
  - Busy duration is N+1 cycles for N>0, and 1 cycle for N=0.
- Earliest next accept is the edge at which state is first IDLE again: EN+2 for N>0, E2 for N=0.
- Intermediate values are visible on data_out1/2 during SHIFT; only values qualified by done are results.
- done and busy are decoded from the state register only, with no combinational path from inputs.

## Test plan
- Reset: assert reset mid-cycle with no clock edge -> busy=0, done=0, data_out1=0000, data_out2=0000 immediately.
- Logical left, amount=1, data_in1=1010, data_in2=0101 -> done high one cycle after E1; data_out1=0100, data_out2=1010; busy high for 2 cycles.
- Rotate right, amount=3, data_in1=1100, data_in2=0011 -> intermediate data_out1 values 0110, 0011, 1001; done after E3 with data_out1=1001, data_out2=0110.
- amount=0, data_in1=1010, data_in2=0101 -> done in the cycle after E0; outputs 1010/0101.
- Logical right, amount=5, data_in1=1111, data_in2=1000 -> done after E5 with 0000/0000. A start pulse with data_in1=0001 injected during SHIFT is ignored: result unchanged, no extra done.
- Rotate left, amount=3, data_in1=0001: assert reset after E2 -> outputs 0000 and IDLE immediately. Then a new start (logical left, amount=2, data_in1=0011, data_in2=0001) -> done after E2 with 1100/0100.
